// File: rtl/result_writeback_packer.sv
// Collects deskewed result rows, packs them as INT32 passthrough or INT8 requantised
// words, and streams them to SRAM through a 2-entry write FIFO at consecutive addresses.
module result_writeback_packer #(
    parameter int ARRAY_SIZE = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int SRAM_WIDTH = 256,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_addr,
    input  logic [15:0]                     cfg_rows,
    input  logic                            cfg_mode,
    input  logic [4:0]                      cfg_shift,
    output logic                            busy,
    output logic                            done,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            sram_wr_en,
    input  logic                            sram_wr_ready,
    output logic [ADDR_WIDTH-1:0]           sram_wr_addr,
    output logic [SRAM_WIDTH-1:0]           sram_wr_data
);

    generate
        if (ARRAY_SIZE * ACC_WIDTH > SRAM_WIDTH) begin : g_width_check
            $error("result_writeback_packer: ARRAY_SIZE*ACC_WIDTH exceeds SRAM_WIDTH");
        end
    endgenerate

    localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH+1)'(127);
    localparam logic signed [ACC_WIDTH:0] Q_MIN = (ACC_WIDTH+1)'(-128);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             rows_reg;
    logic [15:0]             acc_cnt_reg;
    logic                    mode_reg;
    logic [4:0]              shift_reg;
    logic [ADDR_WIDTH-1:0]   addr_ptr_reg;

    logic [ADDR_WIDTH-1:0]   fifo_addr_reg [2];
    logic [SRAM_WIDTH-1:0]   fifo_data_reg [2];
    logic                    wr_ptr_reg;
    logic                    rd_ptr_reg;
    logic [1:0]              count_reg;
    logic [1:0]              count_after_pop;

    logic                    push;
    logic                    pop;
    logic                    last_row;
    logic signed [ACC_WIDTH:0] round_val;
    logic [ACC_WIDTH-1:0]    lane_int32 [ARRAY_SIZE];
    logic [7:0]              lane_int8  [ARRAY_SIZE];
    logic [SRAM_WIDTH-1:0]   packed_row;

    // Rounding constant is half an LSB of the shifted result, zero for no shift.
    always_comb begin
        round_val = '0;
        if (shift_reg != 5'd0) begin
            round_val = (ACC_WIDTH+1)'(1) << (shift_reg - 5'd1);
        end
    end

    // One extra bit of headroom keeps value + rounding from overflowing.
    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            logic signed [ACC_WIDTH-1:0] lane_v;
            logic signed [ACC_WIDTH:0]   lane_rnd;
            logic signed [ACC_WIDTH:0]   lane_shf;

            assign lane_v   = in_data[gi*ACC_WIDTH +: ACC_WIDTH];
            assign lane_rnd = {lane_v[ACC_WIDTH-1], lane_v} + round_val;
            assign lane_shf = lane_rnd >>> shift_reg;
            assign lane_int32[gi] = lane_v;

            always_comb begin
                if (lane_shf > Q_MAX) begin
                    lane_int8[gi] = 8'h7F;
                end else if (lane_shf < Q_MIN) begin
                    lane_int8[gi] = 8'h80;
                end else begin
                    lane_int8[gi] = lane_shf[7:0];
                end
            end
        end
    endgenerate

    always_comb begin
        packed_row = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (mode_reg) begin
                packed_row[i*8 +: 8] = lane_int8[i];
            end else begin
                packed_row[i*ACC_WIDTH +: ACC_WIDTH] = lane_int32[i];
            end
        end
    end

    // in_ready looks at occupancy after this cycle's pop so a full FIFO can refill in-cycle.
    assign sram_wr_en      = (count_reg != 2'd0);
    assign pop             = sram_wr_en & sram_wr_ready;
    assign count_after_pop = count_reg - {1'b0, pop};
    assign in_ready        = (state_reg == RUN) && (acc_cnt_reg < rows_reg) && (count_after_pop != 2'd2);
    assign push            = in_valid & in_ready;
    assign last_row        = (acc_cnt_reg == rows_reg - 16'd1);
    assign sram_wr_addr    = sram_wr_en ? fifo_addr_reg[rd_ptr_reg] : '0;
    assign sram_wr_data    = sram_wr_en ? fifo_data_reg[rd_ptr_reg] : '0;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    state_next = (cfg_rows == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push && last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (count_reg == 2'd0 || (count_reg == 2'd1 && pop)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rows_reg     <= '0;
            acc_cnt_reg  <= '0;
            mode_reg     <= 1'b0;
            shift_reg    <= '0;
            addr_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && cfg_start) begin
                rows_reg     <= cfg_rows;
                mode_reg     <= cfg_mode;
                shift_reg    <= cfg_shift;
                addr_ptr_reg <= cfg_base_addr;
                acc_cnt_reg  <= '0;
            end else if (push) begin
                acc_cnt_reg  <= acc_cnt_reg + 16'd1;
                addr_ptr_reg <= addr_ptr_reg + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr_reg[i] <= '0;
                fifo_data_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                fifo_addr_reg[wr_ptr_reg] <= addr_ptr_reg;
                fifo_data_reg[wr_ptr_reg] <= packed_row;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_result_writeback_packer.sv
// Self-checking bench: table of single-row packing vectors plus hand-written
// multi-cycle sequences, with a scoreboard checked on every accepted SRAM write.
module tb_result_writeback_packer;

    localparam int AS  = 4;
    localparam int AW  = 32;
    localparam int SW  = 256;
    localparam int ADW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_start;
    logic [ADW-1:0]  cfg_base_addr;
    logic [15:0]     cfg_rows;
    logic            cfg_mode;
    logic [4:0]      cfg_shift;
    logic            busy;
    logic            done;
    logic [AS*AW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            sram_wr_en;
    logic            sram_wr_ready;
    logic [ADW-1:0]  sram_wr_addr;
    logic [SW-1:0]   sram_wr_data;

    always #5 clk = ~clk;

    result_writeback_packer #(
        .ARRAY_SIZE(AS), .ACC_WIDTH(AW), .SRAM_WIDTH(SW), .ADDR_WIDTH(ADW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_rows(cfg_rows),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sram_wr_en(sram_wr_en), .sram_wr_ready(sram_wr_ready),
        .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data)
    );

    typedef struct packed {
        logic [ADW-1:0] addr;
        logic [SW-1:0]  data;
    } wr_t;

    typedef struct packed {
        logic           mode;
        logic [4:0]     shift;
        logic [127:0]   row;
        logic [SW-1:0]  exp;
    } vec_t;

    wr_t      sb[$];
    vec_t     vecs[7];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    int       wr_total = 0;
    int       first_wr_cyc = -1;
    int       last_wr_cyc  = -1;
    int       start_cyc    = 0;
    logic [ADW-1:0] job_base;
    int       job_k;
    logic           stall_pending = 1'b0;
    logic [ADW-1:0] held_addr;
    logic [SW-1:0]  held_data;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] row4(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [SW-1:0] q8(int a, int b, int c, int d);
        return {224'b0, 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [SW-1:0] x32(logic [127:0] r);
        return {128'b0, r};
    endfunction

    function automatic vec_t mk(logic m, logic [4:0] s, logic [127:0] r, logic [SW-1:0] e);
        vec_t v;
        v.mode = m; v.shift = s; v.row = r; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [SW-1:0] act, logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pending = 1'b0;
            end else begin
                if (stall_pending) begin
                    check("hold_en", sram_wr_en, 1);
                    check("hold_addr", sram_wr_addr, held_addr);
                    check("hold_data", sram_wr_data, held_data);
                end
                stall_pending = sram_wr_en && !sram_wr_ready;
                held_addr     = sram_wr_addr;
                held_data     = sram_wr_data;
                if (sram_wr_en && sram_wr_ready) begin
                    wr_total++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    $display("write addr=%05h data=%h", sram_wr_addr, sram_wr_data);
                    check("write_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        wr_t e;
                        e = sb.pop_front();
                        check("wr_addr", sram_wr_addr, e.addr);
                        check("wr_data", sram_wr_data, e.data);
                    end
                end
            end
        end
    endtask

    task automatic start_job(logic m, logic [4:0] s, logic [ADW-1:0] base, logic [15:0] rows);
        cfg_mode = m; cfg_shift = s; cfg_base_addr = base; cfg_rows = rows;
        cfg_start = 1'b1;
        job_base  = base;
        job_k     = 0;
        start_cyc = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic feed_row(logic [127:0] row, logic [SW-1:0] exp);
        bit ok = 1'b0;
        wr_t e;
        in_data  = row;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.addr = job_base + ADW'(job_k);
                e.data = exp;
                sb.push_back(e);
                job_k++;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("in_handshake", ok, 1);
    endtask

    task automatic wait_done(output int dcyc);
        bit found = 1'b0;
        dcyc = -1;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
        check("done_seen", found, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int d;
        int w0;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_rows = '0;
        cfg_mode = 1'b0; cfg_shift = '0; in_data = '0; in_valid = 1'b0;
        sram_wr_ready = 1'b1;

        vecs[0] = mk(1'b1, 5'd2,  row4(7, -7, 1000, -1000), q8(2, -2, 127, -128));
        vecs[1] = mk(1'b1, 5'd0,  row4(5, -3, 200, -200), q8(5, -3, 127, -128));
        vecs[2] = mk(1'b1, 5'd4,  row4(8, -8, 24, -24), q8(1, 0, 2, -1));
        vecs[3] = mk(1'b1, 5'd31, row4(32'h7FFFFFFF, 32'h80000000, 1, -1), q8(1, -1, 0, 0));
        vecs[4] = mk(1'b1, 5'd8,  row4(32512, 32640, -32768, -32640), q8(127, 127, -128, -127));
        vecs[5] = mk(1'b0, 5'd0,  row4(1, -1, 32'h7FFFFFFF, 32'h80000000),
                     x32(row4(1, -1, 32'h7FFFFFFF, 32'h80000000)));
        vecs[6] = mk(1'b0, 5'd5,  row4(100, 200, 300, 400), x32(row4(100, 200, 300, 400)));

        fork
            monitor_loop();
        join_none

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", sram_wr_en, 0);
        check("rst_wr_addr", sram_wr_addr, 0);
        check("rst_wr_data", sram_wr_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);

        // Single-row packing vectors
        for (int i = 0; i < 7; i++) begin
            start_job(vecs[i].mode, vecs[i].shift, ADW'(16 + i), 16'd1);
            feed_row(vecs[i].row, vecs[i].exp);
            in_valid = 1'b0;
            wait_done(d);
            check("vec_sb_empty", sb.size(), 0);
        end

        // INT32 burst, full throughput
        first_wr_cyc = -1;
        start_job(1'b0, 5'd0, 20'h20, 16'd4);
        for (int k = 0; k < 4; k++) begin
            feed_row(row4(4*k+1, 4*k+2, 4*k+3, 4*k+4), x32(row4(4*k+1, 4*k+2, 4*k+3, 4*k+4)));
        end
        in_valid = 1'b0;
        wait_done(d);
        check("burst_one_per_cycle", last_wr_cyc - first_wr_cyc, 3);
        check("burst_done_after_last", d, last_wr_cyc + 1);
        check("burst_sb_empty", sb.size(), 0);

        // Backpressure: write ready low for six cycles
        start_job(1'b0, 5'd0, 20'h80, 16'd6);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    feed_row(row4(100+k, 200+k, 300+k, 400+k), x32(row4(100+k, 200+k, 300+k, 400+k)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 sram_wr_ready = 1'b0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", in_ready, 0);
                check("stall_wr_en_high", sram_wr_en, 1);
                @(posedge clk); #1;
                sram_wr_ready = 1'b1;
                @(negedge clk);
                check("full_push_pop_ready", in_ready, 1);
            end
        join
        wait_done(d);
        check("bp_sb_empty", sb.size(), 0);

        // Address wrap
        start_job(1'b0, 5'd0, 20'hFFFFE, 16'd4);
        for (int k = 0; k < 4; k++) begin
            feed_row(row4(k, k+10, k+20, k+30), x32(row4(k, k+10, k+20, k+30)));
        end
        in_valid = 1'b0;
        wait_done(d);
        check("wrap_sb_empty", sb.size(), 0);

        // Zero-row job
        w0 = wr_total;
        start_job(1'b0, 5'd0, 20'h55, 16'd0);
        wait_done(d);
        check("zero_rows_done_cycle", d, start_cyc + 1);
        check("zero_rows_no_write", wr_total, w0);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        @(posedge clk); #1;

        // cfg_start while busy is ignored
        w0 = wr_total;
        start_job(1'b0, 5'd0, 20'h100, 16'd3);
        feed_row(row4(1, 1, 1, 1), x32(row4(1, 1, 1, 1)));
        in_valid = 1'b0;
        cfg_start = 1'b1; cfg_base_addr = 20'h300; cfg_rows = 16'd9; cfg_mode = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        feed_row(row4(2, 2, 2, 2), x32(row4(2, 2, 2, 2)));
        feed_row(row4(3, 3, 3, 3), x32(row4(3, 3, 3, 3)));
        in_valid = 1'b0;
        wait_done(d);
        check("ignored_start_writes", wr_total - w0, 3);
        check("ignored_sb_empty", sb.size(), 0);

        // Reset in the middle of a job
        start_job(1'b1, 5'd1, 20'h40, 16'd4);
        feed_row(row4(2, 4, 6, 8), q8(1, 2, 3, 4));
        feed_row(row4(2, 4, 6, 8), q8(1, 2, 3, 4));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_wr_en", sram_wr_en, 0);
        check("midrst_wr_addr", sram_wr_addr, 0);
        check("midrst_wr_data", sram_wr_data, 0);
        sb.delete();
        w0 = wr_total;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("postrst_busy", busy, 0);
        end
        check("postrst_no_write", wr_total, w0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start_job(1'b0, 5'd0, 20'h60, 16'd2);
        feed_row(row4(9, 8, 7, 6), x32(row4(9, 8, 7, 6)));
        feed_row(row4(5, 4, 3, 2), x32(row4(5, 4, 3, 2)));
        in_valid = 1'b0;
        wait_done(d);
        check("postrst_job_writes", wr_total - w0, 2);
        check("postrst_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
